pwm16bits_carrier: RTL and testbench
====================================

# pwm16bits_carrier

16-bit PWM carrier generator producing the `carrier` / `count_max` pair consumed by the PWM event counter and the comparator stages. Supports up (sawtooth), down and up-down (triangle) counting with a shadowed period register and an external phase-sync load for interleaving modules. Sits directly upstream of the event counter; advances only on `ce` cycles.

## Interface
- `WIDTH`, 16, carrier/period width; only 16 is supported.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `ce`  in  1  count enable; when low, all state holds.
- `count_max_in`  in  16  requested period (peak value); shadowed.
- `carrier_mode`  in  2  0 STOP, 1 UP, 2 DOWN, 3 UPDOWN.
- `sync_in`  in  1  phase-load request, sampled on `ce` cycles.
- `phase`  in  16  carrier value loaded on sync.
- `phase_dir`  in  1  direction after sync in UPDOWN (0 up, 1 down).
- `carrier`  out  16  current carrier value, registered.
- `count_max`  out  16  active (shadowed) period, registered.
- `dir`  out  1  current direction (0 up, 1 down), registered.
- `zero_evt`  out  1  high while `carrier == 0` and mode ≠ STOP.
- `max_evt`  out  1  high while `carrier == count_max` and mode ≠ STOP.

## Operation
- Reset (`rst_n` = 0 at an edge): `carrier` = 0, `count_max` = 0, `dir` = 0, `zero_evt` = 0, `max_evt` = 0. Reset beats `ce`.
- STOP: `carrier` and `dir` frozen; `count_max` <= `count_max_in` every `ce` cycle (transparent shadow). `sync_in` ignored.
- UP: `dir` = 0. If `carrier >= count_max`: `carrier` <= 0, `count_max` <= `count_max_in`; else `carrier` + 1. Period = `count_max` + 1 ce cycles.
- DOWN: `dir` = 1. If `carrier == 0`: `carrier` <= `count_max_in`, `count_max` <= `count_max_in`; else `carrier` − 1.
- UPDOWN: dir up: `carrier` + 1, and `dir` <= 1 on the edge where the new value equals `count_max`. Dir down: `carrier` − 1, and on reaching 0, `dir` <= 0 and `count_max` <= `count_max_in`. `count_max` = 0 holds `carrier` at 0. Period = 2·`count_max` ce cycles.
- Sync (`ce` & `sync_in` & mode ≠ STOP) has priority over counting: `carrier` <= min(`phase`, `count_max`). `dir` <= `phase_dir` in UPDOWN; fixed by mode otherwise. `count_max` is not reloaded.
- Out-of-range recovery (running mode, no sync, `carrier > count_max`, e.g. after a period change in STOP): UP/UPDOWN: `carrier` <= 0, `dir` <= 0. DOWN: `carrier` <= `count_max`.
- Mode change takes effect on the next `ce` cycle. `dir` is forced to the mode value on entry to UP/DOWN and kept on entry to UPDOWN.
- Arithmetic: unsigned 16-bit; never wraps past 0 or 0xFFFF, because the bounds above apply first.

## Timing
- All outputs are registered; `carrier` changes one clock after the qualifying `ce` edge.
- `zero_evt` and `max_evt` are decoded from registered state and aligned with the `carrier` value they flag. Both are high together when `count_max` = 0.
- Shadow period takes effect only at the period boundary defined per mode above; mid-period writes to `count_max_in` never alter the current period.
- `sync_in` latency: the loaded value is visible on `carrier` at the next edge.

## Structure
- Shared defines include: mode encodings (`MODE_STOP/UP/DOWN/UPDOWN`) and direction constants. The event counter already decodes `carrier_mode` with matching values, so it uses the same include.
- Single module, no sub-module. Next-state logic sits in one combinational block, plus one register block.

## Test plan
- Reset, then UP with `count_max_in` = 4: `carrier` 0,1,2,3,4,0; `max_evt` at 4, `zero_evt` at 0.
- UPDOWN with `count_max_in` = 3: `carrier` 0,1,2,3,2,1,0,1; `dir` rises with `carrier` = 3 and falls with 0.
- UP, period 10, change `count_max_in` to 5 at `carrier` = 3: continues to 10, wraps, then new period of 6.
- UPDOWN, `sync_in` with `phase` = 7, `phase_dir` = 1, `count_max` = 5: `carrier` = 5, then 4; with `ce` = 0, no change.
- DOWN, period 3: 3,2,1,0,3. Toggle `ce` every other cycle: each value lasts 2 clocks.
- STOP with `carrier` = 8, set `count_max_in` = 4, switch to UP: `carrier` goes to 0, then counts 1..4. Asserting `rst_n` = 0 mid-count zeroes all outputs next edge.

Source files
------------

// File: rtl/pwm16bits_carrier_pkg.sv
// Shared carrier-mode and direction encodings. The downstream event counter
// decodes carrier_mode with the same values, so both import this package.
package pwm16bits_carrier_pkg;

    localparam logic [1:0] MODE_STOP   = 2'd0;
    localparam logic [1:0] MODE_UP     = 2'd1;
    localparam logic [1:0] MODE_DOWN   = 2'd2;
    localparam logic [1:0] MODE_UPDOWN = 2'd3;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // Smaller of two unsigned 16-bit values; keeps a phase load inside the period.
    function automatic logic [15:0] clamp_to(input logic [15:0] value, input logic [15:0] limit);
        return (value > limit) ? limit : value;
    endfunction

endpackage

// File: rtl/pwm16bits_carrier.sv
// 16-bit PWM carrier generator: sawtooth up/down or triangle counting with a
// shadowed period, phase-sync load and registered zero/peak event flags.
module pwm16bits_carrier
    import pwm16bits_carrier_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ce,
    input  logic [WIDTH-1:0] count_max_in,
    input  logic [1:0]       carrier_mode,
    input  logic             sync_in,
    input  logic [WIDTH-1:0] phase,
    input  logic             phase_dir,
    output logic [WIDTH-1:0] carrier,
    output logic [WIDTH-1:0] count_max,
    output logic             dir,
    output logic             zero_evt,
    output logic             max_evt
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] carrier_n;
    logic [WIDTH-1:0] count_max_n;
    logic             dir_n;
    logic             zero_n;
    logic             max_n;
    logic             running;
    logic             go_down;

    // Next-state for carrier, period shadow, direction and event flags.
    // Event flags are computed from the next state so they line up with the
    // carrier value they describe.
    always_comb begin
        carrier_n   = carrier;
        count_max_n = count_max;
        dir_n       = dir;
        zero_n      = zero_evt;
        max_n       = max_evt;
        running     = (carrier_mode != MODE_STOP);
        go_down     = 1'b0;

        if (ce) begin
            if (!running) begin
                count_max_n = count_max_in;
            end else if (sync_in) begin
                carrier_n = clamp_to(phase, count_max);
                if (carrier_mode == MODE_UPDOWN) dir_n = phase_dir;
                else if (carrier_mode == MODE_DOWN) dir_n = DIR_DOWN;
                else dir_n = DIR_UP;
            end else if (carrier > count_max) begin
                // Period shrank while stopped: pull the carrier back into range.
                if (carrier_mode == MODE_DOWN) begin
                    carrier_n = count_max;
                    dir_n     = DIR_DOWN;
                end else begin
                    carrier_n = '0;
                    dir_n     = DIR_UP;
                end
            end else begin
                case (carrier_mode)
                    MODE_UP: begin
                        dir_n = DIR_UP;
                        if (carrier >= count_max) begin
                            carrier_n   = '0;
                            count_max_n = count_max_in;
                        end else begin
                            carrier_n = carrier + ONE;
                        end
                    end
                    MODE_DOWN: begin
                        dir_n = DIR_DOWN;
                        if (carrier == '0) begin
                            carrier_n   = count_max_in;
                            count_max_n = count_max_in;
                        end else begin
                            carrier_n = carrier - ONE;
                        end
                    end
                    default: begin
                        // Triangle; a zero period parks the carrier at 0 and keeps
                        // polling the shadow so a new period can start.
                        if (count_max == '0) begin
                            carrier_n   = '0;
                            dir_n       = DIR_UP;
                            count_max_n = count_max_in;
                        end else begin
                            go_down = ((dir == DIR_DOWN) && (carrier != '0)) ||
                                      ((dir == DIR_UP) && (carrier == count_max));
                            if (go_down) begin
                                carrier_n = carrier - ONE;
                                dir_n     = DIR_DOWN;
                                if (carrier_n == '0) begin
                                    dir_n       = DIR_UP;
                                    count_max_n = count_max_in;
                                end
                            end else begin
                                carrier_n = carrier + ONE;
                                dir_n     = (carrier_n == count_max) ? DIR_DOWN : DIR_UP;
                            end
                        end
                    end
                endcase
            end

            zero_n = running && (carrier_n == '0);
            max_n  = running && (carrier_n == count_max_n);
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            carrier   <= '0;
            count_max <= '0;
            dir       <= DIR_UP;
            zero_evt  <= 1'b0;
            max_evt   <= 1'b0;
        end else begin
            carrier   <= carrier_n;
            count_max <= count_max_n;
            dir       <= dir_n;
            zero_evt  <= zero_n;
            max_evt   <= max_n;
        end
    end

endmodule

// File: tb/tb_pwm16bits_carrier.sv
// Directed bench for pwm16bits_carrier with hand-computed expected values.
module tb_pwm16bits_carrier;
    import pwm16bits_carrier_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ce;
    logic [15:0] count_max_in;
    logic [1:0]  carrier_mode;
    logic        sync_in;
    logic [15:0] phase;
    logic        phase_dir;
    logic [15:0] carrier;
    logic [15:0] count_max;
    logic        dir;
    logic        zero_evt;
    logic        max_evt;

    int n_pass  = 0;
    int n_total = 0;

    pwm16bits_carrier #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .ce(ce), .count_max_in(count_max_in),
        .carrier_mode(carrier_mode), .sync_in(sync_in), .phase(phase),
        .phase_dir(phase_dir), .carrier(carrier), .count_max(count_max),
        .dir(dir), .zero_evt(zero_evt), .max_evt(max_evt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic chk_all(input string tag, input logic [15:0] c, input logic [15:0] cm,
                           input logic d, input logic z, input logic m);
        chk({tag, ".carrier"},   carrier, c);
        chk({tag, ".count_max"}, count_max, cm);
        chk({tag, ".dir"},       {15'd0, dir}, {15'd0, d});
        chk({tag, ".zero_evt"},  {15'd0, zero_evt}, {15'd0, z});
        chk({tag, ".max_evt"},   {15'd0, max_evt}, {15'd0, m});
    endtask

    initial begin
        rst_n = 1'b0; ce = 1'b1; count_max_in = 16'd0; carrier_mode = MODE_UP;
        sync_in = 1'b0; phase = 16'd0; phase_dir = 1'b0;
        tick();
        chk_all("reset", 16'd0, 16'd0, 1'b0, 1'b0, 1'b0);

        // UP, period 4
        rst_n = 1'b1; carrier_mode = MODE_STOP; count_max_in = 16'd4;
        tick();
        chk_all("up_load", 16'd0, 16'd4, 1'b0, 1'b0, 1'b0);
        carrier_mode = MODE_UP;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk_all("up_cnt", 16'(i), 16'd4, 1'b0, 1'b0, (i == 4));
        end
        tick();
        chk_all("up_wrap", 16'd0, 16'd4, 1'b0, 1'b1, 1'b0);

        // UPDOWN, period 3
        carrier_mode = MODE_STOP; count_max_in = 16'd3;
        tick();
        chk_all("ud_load", 16'd0, 16'd3, 1'b0, 1'b0, 1'b0);
        carrier_mode = MODE_UPDOWN;
        begin
            logic [15:0] exp_c [7] = '{16'd1, 16'd2, 16'd3, 16'd2, 16'd1, 16'd0, 16'd1};
            logic        exp_d [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
            for (int i = 0; i < 7; i++) begin
                tick();
                chk_all("ud_cnt", exp_c[i], 16'd3, exp_d[i], (exp_c[i] == 16'd0), (exp_c[i] == 16'd3));
            end
        end

        // UP, period 10, shadow written mid-period
        carrier_mode = MODE_STOP; count_max_in = 16'd10;
        tick();
        carrier_mode = MODE_UP;
        tick();
        tick();
        chk("shadow_at3", carrier, 16'd3);
        count_max_in = 16'd5;
        for (int i = 4; i <= 10; i++) begin
            tick();
            chk_all("shadow_old", 16'(i), 16'd10, 1'b0, 1'b0, (i == 10));
        end
        tick();
        chk_all("shadow_wrap", 16'd0, 16'd5, 1'b0, 1'b1, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk_all("shadow_new", 16'(i), 16'd5, 1'b0, 1'b0, (i == 5));
        end
        tick();
        chk_all("shadow_wrap2", 16'd0, 16'd5, 1'b0, 1'b1, 1'b0);

        // UPDOWN sync with phase beyond the period
        carrier_mode = MODE_UPDOWN; sync_in = 1'b1; phase = 16'd7; phase_dir = 1'b1;
        tick();
        chk_all("sync_load", 16'd5, 16'd5, 1'b1, 1'b0, 1'b1);
        sync_in = 1'b0;
        tick();
        chk_all("sync_next", 16'd4, 16'd5, 1'b1, 1'b0, 1'b0);
        ce = 1'b0;
        tick();
        tick();
        chk_all("ce_hold", 16'd4, 16'd5, 1'b1, 1'b0, 1'b0);

        // DOWN, period 3, ce every other clock
        ce = 1'b1; carrier_mode = MODE_STOP; count_max_in = 16'd3;
        tick();
        chk_all("dn_load", 16'd4, 16'd3, 1'b1, 1'b0, 1'b0);
        carrier_mode = MODE_DOWN;
        begin
            logic [15:0] exp_c [5] = '{16'd3, 16'd2, 16'd1, 16'd0, 16'd3};
            for (int i = 0; i < 5; i++) begin
                ce = 1'b1;
                tick();
                chk_all("dn_ce1", exp_c[i], 16'd3, 1'b1, (exp_c[i] == 16'd0), (exp_c[i] == 16'd3));
                ce = 1'b0;
                tick();
                chk_all("dn_ce0", exp_c[i], 16'd3, 1'b1, (exp_c[i] == 16'd0), (exp_c[i] == 16'd3));
            end
        end

        // STOP at 8, shrink period to 4, then UP recovers to 0
        ce = 1'b1; carrier_mode = MODE_STOP; count_max_in = 16'd10;
        tick();
        carrier_mode = MODE_UP; sync_in = 1'b1; phase = 16'd8; phase_dir = 1'b1;
        tick();
        chk_all("up_sync", 16'd8, 16'd10, 1'b0, 1'b0, 1'b0);
        sync_in = 1'b0; carrier_mode = MODE_STOP; count_max_in = 16'd4;
        tick();
        chk_all("stop_shrink", 16'd8, 16'd4, 1'b0, 1'b0, 1'b0);
        carrier_mode = MODE_UP;
        tick();
        chk_all("recover", 16'd0, 16'd4, 1'b0, 1'b1, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk_all("rec_cnt", 16'(i), 16'd4, 1'b0, 1'b0, (i == 4));
        end
        tick();
        tick();
        tick();
        chk("pre_rst", carrier, 16'd2);
        rst_n = 1'b0;
        tick();
        chk_all("mid_rst", 16'd0, 16'd0, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
